fe_l2_arb: RTL and testbench
============================

# fe_l2_arb

Front-end L2 request arbiter and miss-tracking controller. It shares the single front-end L2 request port between icache demand misses and the instruction next-line prefetcher. It allocates and tracks outstanding L2 transaction IDs and merges demand misses into matching in-flight prefetches. It routes L2 responses back to the owning requester and drops responses orphaned by a flush.

## Interface
Parameters:
- NUM_OUT, 4: outstanding L2 transactions (power of two, ≥2); ID width IDW = $clog2(NUM_OUT)
- LADDR_W, 26: line-address width
- DATA_W, 512: line data width
- STARVE_LIM, 8: consecutive prefetch losses before a forced prefetch grant

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  nuke/mispredict flush; drops all in-flight and pending work
- dm_req_valid  in  1  icache demand miss request
- dm_req_laddr  in  LADDR_W  demand line address
- dm_req_ready  out  1  demand request accepted this cycle
- pf_req_valid  in  1  prefetch request
- pf_req_laddr  in  LADDR_W  prefetch line address
- pf_req_ready  out  1  prefetch request accepted this cycle
- l2_req_valid  out  1  request to L2
- l2_req_laddr  out  LADDR_W  request line address
- l2_req_id  out  IDW  transaction ID
- l2_req_ready  in  1  L2 accepts request
- l2_rsp_valid  in  1  L2 response (no backpressure)
- l2_rsp_id  in  IDW  response transaction ID
- l2_rsp_data  in  DATA_W  response line
- dm_rsp_valid  out  1  fill to icache
- pf_rsp_valid  out  1  fill to prefetch buffer
- rsp_laddr  out  LADDR_W  line address of the fill
- rsp_data  out  DATA_W  fill data

## Operation
- Tracking table: NUM_OUT entries, each holding {vld, owner (DM/PF), drop, laddr}. The free count is the number of entries with vld=0.
- Output stage: a single registered slot driving l2_req_*. It holds its value until l2_req_valid & l2_req_ready. The slot is "open" when it is empty or is being accepted this cycle.
- Merge check: when dm_req_valid is high and a valid, non-drop PF entry has laddr == dm_req_laddr:
  - the entry's owner becomes DM;
  - dm_req_ready=1;
  - no L2 request is issued.
  - A merge needs neither the output slot nor a free entry.
- Grant rules (evaluated when no merge occurs):
  - A grant requires an open slot and a free entry.
  - Demand has priority.
  - Prefetch is eligible only while free count ≥2, which reserves one entry for demand.
  - If starve_cnt == STARVE_LIM and prefetch is eligible, prefetch wins over demand.
- A merge and a prefetch grant may occur in the same cycle. Demand never gets both a merge and a grant in one cycle.
- Allocation: the lowest-index free entry. On grant the block sets vld=1, owner, drop=0 and laddr, and loads the slot with {laddr, id}.
- starve_cnt (saturating at STARVE_LIM):
  - increments when pf_req_valid is high and prefetch is not granted;
  - clears on a prefetch grant or when pf_req_valid is low.
- Response handling:
  - On l2_rsp_valid, the entry at l2_rsp_id is read.
  - If drop=0, the block drives dm_rsp_valid or pf_rsp_valid according to owner, with rsp_laddr = entry.laddr and rsp_data = l2_rsp_data.
  - The entry is freed in either case.
  - A response to an entry with vld=0 is illegal and covered by an assertion.
- Flush:
  - all vld entries get drop=1;
  - the output slot is cleared, even if unaccepted;
  - dm/pf ready=0 that cycle;
  - starve_cnt clears.
  - Entries remain allocated until their responses return. A slot cleared before acceptance frees its entry immediately.

## Timing
- Reset values:
  - l2_req_valid=0, l2_req_laddr=0, l2_req_id=0;
  - dm/pf_rsp_valid=0, rsp_laddr=0, rsp_data=0;
  - all table entries invalid;
  - starve_cnt=0.
- dm_req_ready and pf_req_ready are combinational from current-cycle inputs and state.
- Request latency: accepted in cycle N → l2_req_valid in cycle N+1, and back-to-back every cycle while L2 is ready.
- Response latency: l2_rsp_valid in cycle M → dm/pf_rsp_valid registered in M+1. The entry is free for allocation in M+1, not in M.
- A response and a flush in the same cycle: the response is dropped and the entry freed.
- A flush and a request in the same cycle: the request is not accepted.
- Table full (free=0): both ready signals are 0 except on a merge.

## Test plan
- Basic demand: dm laddr=0x100, L2 always ready.
  - Required: l2_req_valid in the next cycle with id=0.
  - Response id=0 three cycles later → dm_rsp_valid in the following cycle, rsp_laddr=0x100.
- Prefetch reservation: NUM_OUT=4, with 3 entries filled by prefetches or demands.
  - Required: prefetch is refused (pf_req_ready=0) while a demand is still accepted, using id=3.
- Merge: prefetch 0x200 in flight (id=1), then demand 0x200 arrives.
  - Required: dm_req_ready=1 with no new l2_req.
  - Response id=1 → dm_rsp_valid=1, pf_rsp_valid=0.
- Starvation: demand and prefetch both held valid continuously, STARVE_LIM=8, responses returning promptly.
  - Required: prefetch is granted on the 9th contended cycle.
- Flush: 2 entries in flight and the slot held because l2_req_ready=0, then flush.
  - Required: l2_req_valid=0 in the next cycle.
  - Both later responses produce no rsp_valid.
  - The table is fully free afterward: 4 consecutive demands are accepted.
- Async reset mid-traffic:
  - Required: all outputs reach their reset values without a clock edge.
  - The first post-reset demand gets id=0.

Source files
------------

// File: rtl/fe_l2_arb.sv
// fe_l2_arb: front-end L2 request arbiter and miss-tracking controller.
// Shares one L2 request port between icache demand misses and the next-line
// prefetcher. It allocates transaction IDs and merges a demand into a matching
// in-flight prefetch. Responses go back to the owning requester, and responses
// orphaned by a flush are dropped.
// Ports:
//   clk, reset            core clock, async active-high reset
//   flush                 drops all in-flight and pending work
//   dm_req_* / pf_req_*   demand / prefetch request (valid, laddr, ready)
//   l2_req_*              registered request slot toward L2 (valid, laddr, id, ready)
//   l2_rsp_*              L2 response (valid, id, data), no backpressure
//   dm_rsp_valid, pf_rsp_valid, rsp_laddr, rsp_data   registered fill
module fe_l2_arb #(
    parameter  int unsigned NUM_OUT    = 4,
    parameter  int unsigned LADDR_W    = 26,
    parameter  int unsigned DATA_W     = 512,
    parameter  int unsigned STARVE_LIM = 8,
    localparam int unsigned IDW        = $clog2(NUM_OUT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               dm_req_valid,
    input  logic [LADDR_W-1:0] dm_req_laddr,
    output logic               dm_req_ready,
    input  logic               pf_req_valid,
    input  logic [LADDR_W-1:0] pf_req_laddr,
    output logic               pf_req_ready,
    output logic               l2_req_valid,
    output logic [LADDR_W-1:0] l2_req_laddr,
    output logic [IDW-1:0]     l2_req_id,
    input  logic               l2_req_ready,
    input  logic               l2_rsp_valid,
    input  logic [IDW-1:0]     l2_rsp_id,
    input  logic [DATA_W-1:0]  l2_rsp_data,
    output logic               dm_rsp_valid,
    output logic               pf_rsp_valid,
    output logic [LADDR_W-1:0] rsp_laddr,
    output logic [DATA_W-1:0]  rsp_data
);

    localparam int unsigned CNT_W = $clog2(NUM_OUT + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIM + 1);

    // Tracking table; tbl_dm=1 means the demand side owns the entry.
    logic [NUM_OUT-1:0] tbl_vld;
    logic [NUM_OUT-1:0] tbl_dm;
    logic [NUM_OUT-1:0] tbl_drop;
    logic [LADDR_W-1:0] tbl_laddr [NUM_OUT];

    logic [STV_W-1:0]   starve_cnt;
    logic [CNT_W-1:0]   free_cnt;
    logic [IDW-1:0]     alloc_id;
    logic               alloc_ok;
    logic [NUM_OUT-1:0] merge_hit;
    logic               merge;
    logic               slot_open;
    logic               can_grant;
    logic               pf_elig;
    logic               dm_want;
    logic               force_pf;
    logic               grant_dm;
    logic               grant_pf;

    // Free count and lowest-index free entry (descending scan leaves the lowest).
    always_comb begin : free_scan
        free_cnt = '0;
        alloc_id = '0;
        alloc_ok = 1'b0;
        for (int i = int'(NUM_OUT) - 1; i >= 0; i--) begin
            if (!tbl_vld[i]) begin
                free_cnt = free_cnt + CNT_W'(1);
                alloc_id = IDW'(i);
                alloc_ok = 1'b1;
            end
        end
    end

    // Demand hits an in-flight prefetch. An entry whose response returns this
    // cycle is excluded so the fill is not lost to the prefetch side.
    always_comb begin : merge_scan
        merge_hit = '0;
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            merge_hit[i] = tbl_vld[i] & ~tbl_drop[i] & ~tbl_dm[i]
                         & (tbl_laddr[i] == dm_req_laddr)
                         & ~(l2_rsp_valid & (l2_rsp_id == IDW'(i)));
        end
    end

    // Arbitration: demand first, except a starved prefetch takes the grant.
    // Prefetch needs two free entries so one always stays available for demand.
    always_comb begin : arbitrate
        merge     = dm_req_valid & ~flush & (|merge_hit);
        slot_open = ~l2_req_valid | l2_req_ready;
        can_grant = slot_open & alloc_ok & ~flush;
        pf_elig   = pf_req_valid & (free_cnt >= CNT_W'(2));
        dm_want   = dm_req_valid & ~merge;
        force_pf  = pf_elig & (starve_cnt == STV_W'(STARVE_LIM));
        grant_pf  = can_grant & pf_elig & (force_pf | ~dm_want);
        grant_dm  = can_grant & dm_want & ~force_pf;
    end

    assign dm_req_ready = merge | grant_dm;
    assign pf_req_ready = grant_pf;

    // Table update. Later assignments win: a response frees its entry even
    // under flush, and allocation only targets an entry that is currently free.
    always_ff @(posedge clk or posedge reset) begin : table_upd
        if (reset) begin
            tbl_vld  <= '0;
            tbl_dm   <= '0;
            tbl_drop <= '0;
            for (int i = 0; i < int'(NUM_OUT); i++) begin
                tbl_laddr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_OUT); i++) begin
                if (merge && merge_hit[i]) begin
                    tbl_dm[i] <= 1'b1;
                end
                if (flush && tbl_vld[i]) begin
                    tbl_drop[i] <= 1'b1;
                end
                // An unsent request never reaches L2, so no response will free it.
                if (flush && l2_req_valid && !l2_req_ready && (l2_req_id == IDW'(i))) begin
                    tbl_vld[i] <= 1'b0;
                end
                if (l2_rsp_valid && (l2_rsp_id == IDW'(i))) begin
                    tbl_vld[i] <= 1'b0;
                end
                if ((grant_dm || grant_pf) && (alloc_id == IDW'(i))) begin
                    tbl_vld[i]   <= 1'b1;
                    tbl_dm[i]    <= grant_dm;
                    tbl_drop[i]  <= 1'b0;
                    tbl_laddr[i] <= grant_dm ? dm_req_laddr : pf_req_laddr;
                end
            end
        end
    end

    // Output request slot.
    always_ff @(posedge clk or posedge reset) begin : slot_upd
        if (reset) begin
            l2_req_valid <= 1'b0;
            l2_req_laddr <= '0;
            l2_req_id    <= '0;
        end else if (flush) begin
            l2_req_valid <= 1'b0;
        end else if (grant_dm || grant_pf) begin
            l2_req_valid <= 1'b1;
            l2_req_laddr <= grant_dm ? dm_req_laddr : pf_req_laddr;
            l2_req_id    <= alloc_id;
        end else if (l2_req_ready) begin
            l2_req_valid <= 1'b0;
        end
    end

    // Response routing.
    always_ff @(posedge clk or posedge reset) begin : rsp_upd
        if (reset) begin
            dm_rsp_valid <= 1'b0;
            pf_rsp_valid <= 1'b0;
            rsp_laddr    <= '0;
            rsp_data     <= '0;
        end else begin
            dm_rsp_valid <= l2_rsp_valid & ~flush & tbl_vld[l2_rsp_id]
                          & ~tbl_drop[l2_rsp_id] & tbl_dm[l2_rsp_id];
            pf_rsp_valid <= l2_rsp_valid & ~flush & tbl_vld[l2_rsp_id]
                          & ~tbl_drop[l2_rsp_id] & ~tbl_dm[l2_rsp_id];
            if (l2_rsp_valid) begin
                rsp_laddr <= tbl_laddr[l2_rsp_id];
                rsp_data  <= l2_rsp_data;
            end
        end
    end

    // Prefetch starvation counter, saturating.
    always_ff @(posedge clk or posedge reset) begin : starve_upd
        if (reset) begin
            starve_cnt <= '0;
        end else if (flush || !pf_req_valid || grant_pf) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STV_W'(STARVE_LIM)) begin
            starve_cnt <= starve_cnt + STV_W'(1);
        end
    end

    // A response must target an allocated entry.
    rsp_to_live_entry: assert property (@(posedge clk) disable iff (reset)
        l2_rsp_valid |-> tbl_vld[l2_rsp_id])
        else $error("fe_l2_arb: response to unallocated id %0d", l2_rsp_id);

endmodule

// File: tb/tb_fe_l2_arb.sv
module tb_fe_l2_arb;

    localparam int unsigned NUM_OUT    = 4;
    localparam int unsigned LADDR_W    = 26;
    localparam int unsigned DATA_W     = 512;
    localparam int unsigned STARVE_LIM = 8;
    localparam int unsigned IDW        = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               flush;
    logic               dm_req_valid;
    logic [LADDR_W-1:0] dm_req_laddr;
    logic               dm_req_ready;
    logic               pf_req_valid;
    logic [LADDR_W-1:0] pf_req_laddr;
    logic               pf_req_ready;
    logic               l2_req_valid;
    logic [LADDR_W-1:0] l2_req_laddr;
    logic [IDW-1:0]     l2_req_id;
    logic               l2_req_ready;
    logic               l2_rsp_valid;
    logic [IDW-1:0]     l2_rsp_id;
    logic [DATA_W-1:0]  l2_rsp_data;
    logic               dm_rsp_valid;
    logic               pf_rsp_valid;
    logic [LADDR_W-1:0] rsp_laddr;
    logic [DATA_W-1:0]  rsp_data;

    always #5 clk = ~clk;

    fe_l2_arb #(
        .NUM_OUT(NUM_OUT), .LADDR_W(LADDR_W), .DATA_W(DATA_W), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dm_req_valid(dm_req_valid), .dm_req_laddr(dm_req_laddr), .dm_req_ready(dm_req_ready),
        .pf_req_valid(pf_req_valid), .pf_req_laddr(pf_req_laddr), .pf_req_ready(pf_req_ready),
        .l2_req_valid(l2_req_valid), .l2_req_laddr(l2_req_laddr), .l2_req_id(l2_req_id),
        .l2_req_ready(l2_req_ready),
        .l2_rsp_valid(l2_rsp_valid), .l2_rsp_id(l2_rsp_id), .l2_rsp_data(l2_rsp_data),
        .dm_rsp_valid(dm_rsp_valid), .pf_rsp_valid(pf_rsp_valid),
        .rsp_laddr(rsp_laddr), .rsp_data(rsp_data)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    bit               m_vld   [NUM_OUT];
    bit               m_dm    [NUM_OUT];
    bit               m_drop  [NUM_OUT];
    logic [LADDR_W-1:0] m_laddr [NUM_OUT];
    bit               m_slot_vld;
    logic [LADDR_W-1:0] m_slot_laddr;
    logic [IDW-1:0]   m_slot_id;
    int               m_starve;
    bit               m_dm_rsp;
    bit               m_pf_rsp;
    logic [LADDR_W-1:0] m_rsp_laddr;
    logic [DATA_W-1:0]  m_rsp_data;

    typedef struct packed {
        logic               merge;
        logic [NUM_OUT-1:0] mhit;
        logic               gdm;
        logic               gpf;
        logic [IDW-1:0]     aidx;
    } dec_t;

    dec_t md;

    // What the block decides this cycle, from the current inputs and model state.
    function automatic dec_t decide();
        dec_t d;
        int   nfree;
        bit   found;
        bit   room;
        bit   pf_ok;
        bit   dm_compete;
        d = '0;
        nfree = 0;
        found = 1'b0;
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            if (!m_vld[i]) begin
                nfree++;
                if (!found) begin
                    d.aidx = IDW'(i);
                    found = 1'b1;
                end
            end
        end
        if (dm_req_valid && !flush) begin
            for (int i = 0; i < int'(NUM_OUT); i++) begin
                if (m_vld[i] && !m_drop[i] && !m_dm[i] && m_laddr[i] == dm_req_laddr
                    && !(l2_rsp_valid && int'(l2_rsp_id) == i))
                    d.mhit[i] = 1'b1;
            end
        end
        d.merge    = |d.mhit;
        room       = !flush && nfree > 0 && (!m_slot_vld || l2_req_ready);
        dm_compete = dm_req_valid && !d.merge;
        pf_ok      = pf_req_valid && nfree >= 2;
        if (room) begin
            if (pf_ok && m_starve == int'(STARVE_LIM)) d.gpf = 1'b1;
            else if (dm_compete)                       d.gdm = 1'b1;
            else if (pf_ok)                            d.gpf = 1'b1;
        end
        return d;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_OUT); i++) begin
                m_vld[i] = 1'b0; m_dm[i] = 1'b0; m_drop[i] = 1'b0; m_laddr[i] = '0;
            end
            m_slot_vld = 1'b0; m_slot_laddr = '0; m_slot_id = '0; m_starve = 0;
            m_dm_rsp = 1'b0; m_pf_rsp = 1'b0; m_rsp_laddr = '0; m_rsp_data = '0;
        end else begin
            md = decide();
            m_dm_rsp = 1'b0;
            m_pf_rsp = 1'b0;
            if (l2_rsp_valid) begin
                if (!flush && m_vld[l2_rsp_id] && !m_drop[l2_rsp_id]) begin
                    m_dm_rsp = m_dm[l2_rsp_id];
                    m_pf_rsp = !m_dm[l2_rsp_id];
                end
                m_rsp_laddr = m_laddr[l2_rsp_id];
                m_rsp_data  = l2_rsp_data;
            end
            for (int i = 0; i < int'(NUM_OUT); i++)
                if (md.mhit[i]) m_dm[i] = 1'b1;
            if (flush) begin
                for (int i = 0; i < int'(NUM_OUT); i++)
                    if (m_vld[i]) m_drop[i] = 1'b1;
                if (m_slot_vld && !l2_req_ready) m_vld[m_slot_id] = 1'b0;
            end
            if (l2_rsp_valid) m_vld[l2_rsp_id] = 1'b0;
            if (md.gdm || md.gpf) begin
                m_vld[md.aidx]   = 1'b1;
                m_dm[md.aidx]    = md.gdm;
                m_drop[md.aidx]  = 1'b0;
                m_laddr[md.aidx] = md.gdm ? dm_req_laddr : pf_req_laddr;
            end
            if (flush) m_slot_vld = 1'b0;
            else if (md.gdm || md.gpf) begin
                m_slot_vld   = 1'b1;
                m_slot_laddr = md.gdm ? dm_req_laddr : pf_req_laddr;
                m_slot_id    = md.aidx;
            end else if (l2_req_ready) m_slot_vld = 1'b0;
            if (flush || !pf_req_valid || md.gpf) m_starve = 0;
            else if (m_starve < int'(STARVE_LIM)) m_starve++;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        dec_t d;
        d = decide();
        chk("dm_req_ready", DATA_W'(dm_req_ready), DATA_W'(d.merge | d.gdm));
        chk("pf_req_ready", DATA_W'(pf_req_ready), DATA_W'(d.gpf));
        chk("l2_req_valid", DATA_W'(l2_req_valid), DATA_W'(m_slot_vld));
        if (m_slot_vld) begin
            chk("l2_req_laddr", DATA_W'(l2_req_laddr), DATA_W'(m_slot_laddr));
            chk("l2_req_id", DATA_W'(l2_req_id), DATA_W'(m_slot_id));
        end
        chk("dm_rsp_valid", DATA_W'(dm_rsp_valid), DATA_W'(m_dm_rsp));
        chk("pf_rsp_valid", DATA_W'(pf_rsp_valid), DATA_W'(m_pf_rsp));
        if (m_dm_rsp || m_pf_rsp) begin
            chk("rsp_laddr", DATA_W'(rsp_laddr), DATA_W'(m_rsp_laddr));
            chk("rsp_data", rsp_data, m_rsp_data);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    bit             auto_rsp = 1'b0;
    logic [IDW-1:0] rsp_q[$];

    function automatic logic [DATA_W-1:0] mkdata(input logic [7:0] tag);
        return {16{24'hC0FFEE, tag}};
    endfunction

    task automatic half();
        @(negedge clk);
        model_compare();
    endtask

    // Advance to just after the next rising edge; the auto responder answers
    // each accepted request in the following cycle.
    task automatic rise();
        bit             acc;
        logic [IDW-1:0] aid;
        logic [IDW-1:0] rid;
        acc = l2_req_valid && l2_req_ready;
        aid = l2_req_id;
        @(posedge clk);
        #1;
        if (auto_rsp) begin
            if (acc) rsp_q.push_back(aid);
            if (rsp_q.size() > 0) begin
                rid          = rsp_q.pop_front();
                l2_rsp_valid = 1'b1;
                l2_rsp_id    = rid;
                l2_rsp_data  = mkdata(8'h40 + 8'(rid));
            end else begin
                l2_rsp_valid = 1'b0;
            end
        end
    endtask

    task automatic cyc();
        half();
        rise();
    endtask

    task automatic respond(input logic [IDW-1:0] id, input logic [7:0] tag);
        l2_rsp_valid = 1'b1;
        l2_rsp_id    = id;
        l2_rsp_data  = mkdata(tag);
        cyc();
        l2_rsp_valid = 1'b0;
    endtask

    int got;

    initial begin
        reset = 1'b1; flush = 1'b0;
        dm_req_valid = 1'b0; dm_req_laddr = '0;
        pf_req_valid = 1'b0; pf_req_laddr = '0;
        l2_req_ready = 1'b1; l2_rsp_valid = 1'b0; l2_rsp_id = '0; l2_rsp_data = '0;
        repeat (3) cyc();
        chk("reset_l2_req_valid", DATA_W'(l2_req_valid), DATA_W'(0));
        reset = 1'b0;

        // Basic demand
        dm_req_valid = 1'b1; dm_req_laddr = 26'h100;
        half();
        chk("t1_dm_ready", DATA_W'(dm_req_ready), DATA_W'(1));
        rise();
        dm_req_valid = 1'b0;
        half();
        chk("t1_l2_valid", DATA_W'(l2_req_valid), DATA_W'(1));
        chk("t1_l2_id", DATA_W'(l2_req_id), DATA_W'(0));
        chk("t1_l2_laddr", DATA_W'(l2_req_laddr), DATA_W'('h100));
        rise();
        cyc(); cyc();
        respond(2'd0, 8'h11);
        half();
        chk("t1_dm_rsp", DATA_W'(dm_rsp_valid), DATA_W'(1));
        chk("t1_rsp_laddr", DATA_W'(rsp_laddr), DATA_W'('h100));
        chk("t1_rsp_data", rsp_data, mkdata(8'h11));
        rise();

        // Prefetch reservation
        pf_req_valid = 1'b1; pf_req_laddr = 26'h10;
        half();
        chk("t2_pf_ready0", DATA_W'(pf_req_ready), DATA_W'(1));
        rise();
        pf_req_laddr = 26'h11;
        cyc();
        pf_req_valid = 1'b0; dm_req_valid = 1'b1; dm_req_laddr = 26'h12;
        cyc();
        pf_req_valid = 1'b1; pf_req_laddr = 26'h13; dm_req_laddr = 26'h14;
        half();
        chk("t2_pf_refused", DATA_W'(pf_req_ready), DATA_W'(0));
        chk("t2_dm_accepted", DATA_W'(dm_req_ready), DATA_W'(1));
        rise();
        pf_req_valid = 1'b0; dm_req_valid = 1'b0;
        half();
        chk("t2_id3", DATA_W'(l2_req_id), DATA_W'(3));
        rise();
        dm_req_valid = 1'b1; dm_req_laddr = 26'h15;
        half();
        chk("t2_full_dm_ready", DATA_W'(dm_req_ready), DATA_W'(0));
        rise();
        dm_req_valid = 1'b0;
        respond(2'd0, 8'h20);
        half();
        chk("t2_pf_rsp", DATA_W'(pf_rsp_valid), DATA_W'(1));
        chk("t2_pf_rsp_laddr", DATA_W'(rsp_laddr), DATA_W'('h10));
        rise();
        for (int i = 1; i < 4; i++) respond(IDW'(i), 8'(8'h20 + i));
        cyc();

        // Merge
        dm_req_valid = 1'b1; dm_req_laddr = 26'h300;
        cyc();
        dm_req_valid = 1'b0; pf_req_valid = 1'b1; pf_req_laddr = 26'h200;
        cyc();
        pf_req_valid = 1'b0; dm_req_valid = 1'b1; dm_req_laddr = 26'h200;
        half();
        chk("t3_merge_ready", DATA_W'(dm_req_ready), DATA_W'(1));
        rise();
        dm_req_valid = 1'b0;
        half();
        chk("t3_no_l2_req", DATA_W'(l2_req_valid), DATA_W'(0));
        rise();
        respond(2'd1, 8'h31);
        half();
        chk("t3_dm_rsp", DATA_W'(dm_rsp_valid), DATA_W'(1));
        chk("t3_pf_rsp", DATA_W'(pf_rsp_valid), DATA_W'(0));
        chk("t3_rsp_laddr", DATA_W'(rsp_laddr), DATA_W'('h200));
        rise();
        respond(2'd0, 8'h30);
        cyc();

        // Starvation
        auto_rsp = 1'b1;
        got = 0;
        dm_req_valid = 1'b1; pf_req_valid = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            dm_req_laddr = LADDR_W'(32'h1000 + n);
            pf_req_laddr = LADDR_W'(32'h2000 + n);
            half();
            if (pf_req_ready && got == 0) got = n;
            rise();
            if (got != 0) break;
        end
        chk("t4_starve_grant_cycle", DATA_W'(got), DATA_W'(9));
        dm_req_valid = 1'b0; pf_req_valid = 1'b0;
        repeat (5) cyc();
        auto_rsp = 1'b0; l2_rsp_valid = 1'b0;
        cyc();

        // Flush
        dm_req_valid = 1'b1; dm_req_laddr = 26'h400;
        cyc();
        dm_req_laddr = 26'h401;
        cyc();
        dm_req_laddr = 26'h402;
        cyc();
        dm_req_valid = 1'b0; l2_req_ready = 1'b0;
        cyc();
        flush = 1'b1; dm_req_valid = 1'b1; dm_req_laddr = 26'h403;
        l2_rsp_valid = 1'b1; l2_rsp_id = 2'd0; l2_rsp_data = mkdata(8'h50);
        half();
        chk("t5_flush_dm_ready", DATA_W'(dm_req_ready), DATA_W'(0));
        rise();
        flush = 1'b0; dm_req_valid = 1'b0; l2_rsp_valid = 1'b0;
        half();
        chk("t5_slot_cleared", DATA_W'(l2_req_valid), DATA_W'(0));
        chk("t5_rsp0_dropped", DATA_W'(dm_rsp_valid | pf_rsp_valid), DATA_W'(0));
        rise();
        l2_req_ready = 1'b1;
        respond(2'd1, 8'h51);
        half();
        chk("t5_rsp1_dropped", DATA_W'(dm_rsp_valid | pf_rsp_valid), DATA_W'(0));
        rise();
        dm_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dm_req_laddr = LADDR_W'(32'h500 + k);
            half();
            chk("t5_refill_ready", DATA_W'(dm_req_ready), DATA_W'(1));
            rise();
        end
        dm_req_valid = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) respond(IDW'(i), 8'(8'h60 + i));
        cyc();

        // Async reset mid-traffic
        auto_rsp = 1'b1;
        dm_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dm_req_laddr = LADDR_W'(32'h600 + k);
            cyc();
        end
        chk("t6_pre_l2_valid", DATA_W'(l2_req_valid), DATA_W'(1));
        chk("t6_pre_dm_rsp", DATA_W'(dm_rsp_valid), DATA_W'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_l2_valid", DATA_W'(l2_req_valid), DATA_W'(0));
        chk("t6_rst_l2_laddr", DATA_W'(l2_req_laddr), DATA_W'(0));
        chk("t6_rst_l2_id", DATA_W'(l2_req_id), DATA_W'(0));
        chk("t6_rst_dm_rsp", DATA_W'(dm_rsp_valid), DATA_W'(0));
        chk("t6_rst_pf_rsp", DATA_W'(pf_rsp_valid), DATA_W'(0));
        chk("t6_rst_rsp_laddr", DATA_W'(rsp_laddr), DATA_W'(0));
        chk("t6_rst_rsp_data", rsp_data, DATA_W'(0));
        dm_req_valid = 1'b0; auto_rsp = 1'b0; l2_rsp_valid = 1'b0;
        rsp_q.delete();
        cyc(); cyc();
        reset = 1'b0;
        dm_req_valid = 1'b1; dm_req_laddr = 26'h700;
        half();
        chk("t6_post_dm_ready", DATA_W'(dm_req_ready), DATA_W'(1));
        rise();
        dm_req_valid = 1'b0;
        half();
        chk("t6_post_id0", DATA_W'(l2_req_id), DATA_W'(0));
        chk("t6_post_valid", DATA_W'(l2_req_valid), DATA_W'(1));
        rise();
        respond(2'd0, 8'h70);
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
